// File: rtl/qspi_flash_target_if.sv
// QSPI pin bundle between a flash controller (master) and the flash target (slave).
interface qspi_flash_target_if;
  logic       sclk_i;
  logic       csb_i;
  logic [3:0] sio_i;
  logic [3:0] sio_o;
  logic [3:0] sio_oe;

  modport master (output sclk_i, csb_i, sio_i, input  sio_o, sio_oe);
  modport slave  (input  sclk_i, csb_i, sio_i, output sio_o, sio_oe);
endinterface

// File: rtl/qspi_flash_target.sv
// QSPI NOR-flash responder: oversamples the serial pins in the clk_i domain,
// decodes command / 24-bit address / dummy cycles and serves READ, PAGE
// PROGRAM and READ ID from an internal byte array (SPI mode 0).
// Optional feature macro: QSPI_TARGET_QUAD_EN adds commands 6B/32, the DUMMY
// state and the quad datapath.
module qspi_flash_target #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [23:0] ID_VALUE     = 24'hEF4018
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  qspi_flash_target_if.slave qspi,
  output logic               busy_o,
  output logic [7:0]         cmd_o,
  output logic               cmd_valid_o,
  output logic               err_o
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef QSPI_TARGET_QUAD_EN
  localparam int unsigned SIO_W    = 4;
  localparam logic [3:0]  PIN_MASK = 4'b1111;
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_ID, S_DISCARD
  } state_e;
`else
  localparam int unsigned SIO_W    = 1;
  localparam logic [3:0]  PIN_MASK = 4'b0010;
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_ID, S_DISCARD
  } state_e;
`endif

  // Synchronizers and edge strobes
  logic             sclk_meta_q, sclk_sync_q, sclk_prev_q, sclk_rise_q, sclk_fall_q;
  logic             csb_meta_q, csb_sync_q, csb_prev_q, csb_rise_q, csb_fall_q;
  logic [SIO_W-1:0] sio_meta_q, sio_sync_q;
  logic             busy_q;

  // Protocol state
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              wr_q, wr_d;
`ifdef QSPI_TARGET_QUAD_EN
  logic              quad_q, quad_d;
`endif
  logic [3:0]        sio_o_q, sio_o_d;
  logic [3:0]        sio_oe_q, sio_oe_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              err_q, err_d;
  logic              byte_done;

  // Memory array and its write port
  logic [7:0] mem_q [DEPTH];
  logic       mem_we;
  logic [7:0] mem_wdata;

  // Two-flop synchronizers, then a registered edge detector on sclk and csb.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      csb_meta_q  <= 1'b1;
      csb_sync_q  <= 1'b1;
      csb_prev_q  <= 1'b1;
      csb_rise_q  <= 1'b0;
      csb_fall_q  <= 1'b0;
      sio_meta_q  <= '0;
      sio_sync_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      sclk_meta_q <= qspi.sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      sclk_rise_q <= sclk_sync_q & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_sync_q & sclk_prev_q;
      csb_meta_q  <= qspi.csb_i;
      csb_sync_q  <= csb_meta_q;
      csb_prev_q  <= csb_sync_q;
      csb_rise_q  <= csb_sync_q & ~csb_prev_q;
      csb_fall_q  <= ~csb_sync_q & csb_prev_q;
      sio_meta_q  <= qspi.sio_i[SIO_W-1:0];
      sio_sync_q  <= sio_meta_q;
      busy_q      <= ~csb_sync_q;
    end
  end

  // Next-state and output logic, advanced only on sclk/csb strobes.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    shreg_d     = shreg_q;
    wr_d        = wr_q;
`ifdef QSPI_TARGET_QUAD_EN
    quad_d      = quad_q;
`endif
    sio_o_d     = sio_o_q;
    sio_oe_d    = sio_oe_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;
    byte_done   = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;

    if (csb_rise_q) begin
      // csb rising wins over any same-cycle byte completion: partial bytes are dropped.
      state_d  = S_IDLE;
      cnt_d    = '0;
      sio_o_d  = 4'b0000;
      sio_oe_d = 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (csb_fall_q) begin
            state_d = S_CMD;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end

        S_CMD: begin
          if (sclk_rise_q) begin
            shreg_d = {shreg_q[6:0], sio_sync_q[0]};
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d       = '0;
              cmd_d       = shreg_d;
              cmd_valid_d = 1'b1;
              state_d     = S_DISCARD;
`ifdef QSPI_TARGET_QUAD_EN
              quad_d      = 1'b0;
`endif
              case (shreg_d)
                8'h03: begin state_d = S_ADDR; wr_d = 1'b0; end
                8'h02: begin state_d = S_ADDR; wr_d = 1'b1; end
`ifdef QSPI_TARGET_QUAD_EN
                8'h6B: begin state_d = S_ADDR; wr_d = 1'b0; quad_d = 1'b1; end
                8'h32: begin state_d = S_ADDR; wr_d = 1'b1; quad_d = 1'b1; end
`endif
                8'h9F: state_d = S_ID;
                default: err_d = 1'b1;
              endcase
            end
          end
        end

        S_ADDR: begin
          if (sclk_rise_q) begin
            // Only the low ADDR_W bits survive the 24-bit shift.
            addr_d = {addr_q[ADDR_W-2:0], sio_sync_q[0]};
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == 8'd23) begin
              cnt_d   = '0;
              shreg_d = '0;
              if (wr_q) begin
                state_d = S_WDATA;
`ifdef QSPI_TARGET_QUAD_EN
              end else if (quad_q && (DUMMY_CYCLES != 0)) begin
                state_d = S_DUMMY;
`endif
              end else begin
                state_d = S_RDATA;
                shreg_d = mem_q[addr_d];
              end
            end
          end
        end

`ifdef QSPI_TARGET_QUAD_EN
        S_DUMMY: begin
          if (sclk_rise_q) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = S_RDATA;
              shreg_d = mem_q[addr_q];
            end
          end
        end
`endif

        S_RDATA: begin
          if (sclk_fall_q) begin
            cnt_d = cnt_q + 8'd1;
`ifdef QSPI_TARGET_QUAD_EN
            if (quad_q) begin
              sio_o_d   = shreg_q[7:4];
              sio_oe_d  = 4'b1111;
              shreg_d   = {shreg_q[3:0], 4'h0};
              byte_done = (cnt_q == 8'd1);
            end else
`endif
            begin
              sio_o_d   = {2'b00, shreg_q[7], 1'b0};
              sio_oe_d  = 4'b0010;
              shreg_d   = {shreg_q[6:0], 1'b0};
              byte_done = (cnt_q == 8'd7);
            end
            if (byte_done) begin
              cnt_d   = '0;
              addr_d  = addr_q + ADDR_ONE;
              shreg_d = mem_q[addr_d];
            end
          end
        end

        S_WDATA: begin
          if (sclk_rise_q) begin
            cnt_d = cnt_q + 8'd1;
`ifdef QSPI_TARGET_QUAD_EN
            if (quad_q) begin
              shreg_d   = {shreg_q[3:0], sio_sync_q};
              byte_done = (cnt_q == 8'd1);
            end else
`endif
            begin
              shreg_d   = {shreg_q[6:0], sio_sync_q[0]};
              byte_done = (cnt_q == 8'd7);
            end
            if (byte_done) begin
              // Programming can only clear bits of an erased cell.
              mem_we    = 1'b1;
              mem_wdata = mem_q[addr_q] & shreg_d;
              cnt_d     = '0;
              addr_d    = addr_q + ADDR_ONE;
            end
          end
        end

        S_ID: begin
          if (sclk_fall_q) begin
            sio_o_d  = {2'b00, ID_VALUE[5'd23 - cnt_q[4:0]], 1'b0};
            sio_oe_d = 4'b0010;
            cnt_d    = (cnt_q == 8'd23) ? 8'd0 : cnt_q + 8'd1;
          end
        end

        S_DISCARD: ;

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      shreg_q     <= '0;
      wr_q        <= 1'b0;
`ifdef QSPI_TARGET_QUAD_EN
      quad_q      <= 1'b0;
`endif
      sio_o_q     <= '0;
      sio_oe_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      shreg_q     <= shreg_d;
      wr_q        <= wr_d;
`ifdef QSPI_TARGET_QUAD_EN
      quad_q      <= quad_d;
`endif
      sio_o_q     <= sio_o_d;
      sio_oe_q    <= sio_oe_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
    end
  end

  // Byte array, erased to FF by reset.
  // NOTE: the array is deliberately reset (built from flops) so every reset restores erased flash.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'hFF;
    end else if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  assign qspi.sio_o  = sio_o_q & PIN_MASK;
  assign qspi.sio_oe = sio_oe_q & PIN_MASK;
  assign busy_o      = busy_q;
  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_qspi_flash_target.sv
// Self-checking bench for qspi_flash_target: a bus-level QSPI controller model
// drives transactions; results are compared with a byte-array reference model.
module tb_qspi_flash_target;

  localparam int          HP     = 60;   // sclk half period (6 clk_i cycles)
  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [23:0] ID     = 24'hEF4018;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       busy_o;
  logic [7:0] cmd_o;
  logic       cmd_valid_o;
  logic       err_o;

  qspi_flash_target_if qif ();

  qspi_flash_target #(
    .ADDR_W      (ADDR_W),
    .DUMMY_CYCLES(8),
    .ID_VALUE    (ID)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .qspi       (qif),
    .busy_o     (busy_o),
    .cmd_o      (cmd_o),
    .cmd_valid_o(cmd_valid_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_pulses = 0;
  int err_pulses   = 0;
  int oe_bad       = 0;

  logic [7:0] model_mem [DEPTH];

  // Count clk_i cycles with the pulse outputs high.
  always @(negedge clk_i) begin
    if (cmd_valid_o === 1'b1) valid_pulses++;
    if (err_o === 1'b1) err_pulses++;
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
  endtask

  function automatic int maddr(input logic [23:0] a, input int off);
    return (int'(a) + off) % DEPTH;
  endfunction

  // ---------------- pin-level controller ----------------
  // One sclk period starting just after a falling edge; returns what the
  // target drives just before the rising edge.
  task automatic cyc(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] doe);
    qif.sio_i = din;
    #(HP - 1);
    dout = qif.sio_o;
    doe  = qif.sio_oe;
    #1;
    qif.sclk_i = 1'b1;
    #(HP);
    qif.sclk_i = 1'b0;
  endtask

  task automatic cs_begin();
    qif.csb_i = 1'b0;
    #(HP);
  endtask

  task automatic cs_end();
    qif.csb_i = 1'b1;
    #(HP * 4);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    logic [3:0] d, oe;
    logic [2:0] junk;
    for (int i = 7; i >= 0; i--) begin
      junk = 3'($urandom);
      cyc({junk, b[i]}, d, oe);
    end
  endtask

  task automatic tx_addr(input logic [23:0] a);
    tx_byte(a[23:16]);
    tx_byte(a[15:8]);
    tx_byte(a[7:0]);
  endtask

  task automatic tx_quad(input logic [7:0] b);
    logic [3:0] d, oe;
    cyc(b[7:4], d, oe);
    cyc(b[3:0], d, oe);
  endtask

  task automatic rx_byte(output logic [7:0] b);
    logic [3:0] d, oe;
    for (int i = 7; i >= 0; i--) begin
      cyc(4'($urandom), d, oe);
      b[i] = d[1];
      if (oe !== 4'b0010) oe_bad++;
    end
  endtask

  task automatic rx_quad(output logic [7:0] b);
    logic [3:0] d, oe;
    cyc(4'($urandom), d, oe);
    b[7:4] = d;
    if (oe !== 4'b1111) oe_bad++;
    cyc(4'($urandom), d, oe);
    b[3:0] = d;
    if (oe !== 4'b1111) oe_bad++;
  endtask

  // Program transaction; the model applies AND semantics with address wrap.
  task automatic do_program(input logic [7:0] cmd, input logic [23:0] a, input logic [7:0] data [$]);
    cs_begin();
    tx_byte(cmd);
    tx_addr(a);
    foreach (data[i]) begin
      if (cmd == 8'h32) tx_quad(data[i]);
      else tx_byte(data[i]);
    end
    cs_end();
    foreach (data[i]) model_mem[maddr(a, i)] = model_mem[maddr(a, i)] & data[i];
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [23:0] a, input int n, output logic [7:0] got [$]);
    logic [3:0] d, oe;
    logic [7:0] b;
    got = {};
    cs_begin();
    tx_byte(cmd);
    tx_addr(a);
    if (cmd == 8'h6B) begin
      for (int i = 0; i < 8; i++) begin
        cyc(4'($urandom), d, oe);
        if (oe !== 4'b0000) oe_bad++;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (cmd == 8'h6B) rx_quad(b);
      else rx_byte(b);
      got.push_back(b);
    end
    cs_end();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b1;
    qif.sclk_i = 1'b0;
    qif.csb_i  = 1'b1;
    qif.sio_i  = 4'h0;
    model_reset();
    #20;
    tests_run++; if (qif.sio_o !== 4'h0) begin tests_failed++; $display("FAIL reset_sio_o: got %h want 0", qif.sio_o); end
    tests_run++; if (qif.sio_oe !== 4'h0) begin tests_failed++; $display("FAIL reset_sio_oe: got %h want 0", qif.sio_oe); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests_run++; if (cmd_o !== 8'h00) begin tests_failed++; $display("FAIL reset_cmd: got %h want 00", cmd_o); end
    tests_run++; if (cmd_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid_o); end
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_o); end
    rst_ni = 1'b0;
    #40;
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_read_after_reset();
    logic [7:0] got [$];
    int v0;
    v0 = valid_pulses;
    oe_bad = 0;
    do_read(8'h03, 24'h000010, 2, got);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (got[i] !== model_mem[maddr(24'h10, i)])
        begin tests_failed++; $display("FAIL read_erased[%0d]: got %h want %h", i, got[i], model_mem[maddr(24'h10, i)]); end
    end
    tests_run++; if (cmd_o !== 8'h03) begin tests_failed++; $display("FAIL read_cmd_o: got %h want 03", cmd_o); end
    tests_run++; if (valid_pulses - v0 != 1) begin tests_failed++; $display("FAIL read_cmd_valid_pulses: got %0d want 1", valid_pulses - v0); end
    tests_run++; if (oe_bad != 0) begin tests_failed++; $display("FAIL read_oe: got %0d bad cycles want 0", oe_bad); end
  endtask

  task automatic test_program_wrap();
    logic [7:0] data [$];
    logic [7:0] got [$];
    data = '{8'hA5, 8'h3C, 8'h0F};
    do_program(8'h02, 24'h0000FE, data);
    oe_bad = 0;
    do_read(8'h03, 24'h0000FE, 3, got);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (got[i] !== model_mem[maddr(24'hFE, i)])
        begin tests_failed++; $display("FAIL wrap_read[%0d]: got %h want %h", i, got[i], model_mem[maddr(24'hFE, i)]); end
    end
    tests_run++; if (oe_bad != 0) begin tests_failed++; $display("FAIL wrap_oe: got %0d bad cycles want 0", oe_bad); end
  endtask

  task automatic test_and_semantics();
    logic [7:0] data [$];
    logic [7:0] got [$];
    data = '{8'hF0};
    do_program(8'h02, 24'h000020, data);
    data = '{8'h3C};
    do_program(8'h02, 24'h000020, data);
    do_read(8'h03, 24'h000020, 1, got);
    tests_run++;
    if (got[0] !== model_mem[8'h20]) begin tests_failed++; $display("FAIL and_read: got %h want %h", got[0], model_mem[8'h20]); end
  endtask

  task automatic test_quad();
`ifdef QSPI_TARGET_QUAD_EN
    logic [7:0] data [$];
    logic [7:0] got [$];
    data = '{8'h12, 8'h34};
    do_program(8'h32, 24'h000040, data);
    oe_bad = 0;
    do_read(8'h6B, 24'h000040, 2, got);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (got[i] !== model_mem[maddr(24'h40, i)])
        begin tests_failed++; $display("FAIL quad_read[%0d]: got %h want %h", i, got[i], model_mem[maddr(24'h40, i)]); end
    end
    tests_run++; if (oe_bad != 0) begin tests_failed++; $display("FAIL quad_oe: got %0d bad cycles want 0", oe_bad); end
    tests_run++; if (cmd_o !== 8'h6B) begin tests_failed++; $display("FAIL quad_cmd_o: got %h want 6b", cmd_o); end
`else
    logic [7:0] cmds [2];
    logic [3:0] d, oe;
    int e0, bad;
    cmds[0] = 8'h6B;
    cmds[1] = 8'h32;
    for (int c = 0; c < 2; c++) begin
      e0  = err_pulses;
      bad = 0;
      cs_begin();
      tx_byte(cmds[c]);
      for (int i = 0; i < 16; i++) begin
        cyc(4'($urandom), d, oe);
        if (oe !== 4'h0 || d !== 4'h0) bad++;
      end
      cs_end();
      tests_run++; if (err_pulses - e0 != 1) begin tests_failed++; $display("FAIL noquad_err[%h]: got %0d pulses want 1", cmds[c], err_pulses - e0); end
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL noquad_idle[%h]: got %0d active cycles want 0", cmds[c], bad); end
    end
`endif
  endtask

  task automatic test_read_id();
    logic [3:0]  d, oe;
    logic [7:0]  got, exp;
    logic [23:0] id_v;
    id_v   = ID;
    oe_bad = 0;
    cs_begin();
    tx_byte(8'h9F);
    for (int by = 0; by < 4; by++) begin
      for (int bt = 0; bt < 8; bt++) begin
        cyc(4'($urandom), d, oe);
        got[7 - bt] = d[1];
        exp[7 - bt] = id_v[23 - ((by * 8 + bt) % 24)];
        if (oe !== 4'b0010) oe_bad++;
      end
      tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL read_id[%0d]: got %h want %h", by, got, exp); end
    end
    cs_end();
    tests_run++; if (oe_bad != 0) begin tests_failed++; $display("FAIL read_id_oe: got %0d bad cycles want 0", oe_bad); end
  endtask

  task automatic test_bad_cmd();
    logic [3:0] d, oe;
    int e0, v0, bad;
    e0  = err_pulses;
    v0  = valid_pulses;
    bad = 0;
    cs_begin();
    tx_byte(8'hAB);
    for (int i = 0; i < 16; i++) begin
      cyc(4'($urandom), d, oe);
      if (oe !== 4'h0 || d !== 4'h0) bad++;
    end
    cs_end();
    tests_run++; if (err_pulses - e0 != 1) begin tests_failed++; $display("FAIL bad_cmd_err: got %0d pulses want 1", err_pulses - e0); end
    tests_run++; if (valid_pulses - v0 != 1) begin tests_failed++; $display("FAIL bad_cmd_valid: got %0d pulses want 1", valid_pulses - v0); end
    tests_run++; if (cmd_o !== 8'hAB) begin tests_failed++; $display("FAIL bad_cmd_o: got %h want ab", cmd_o); end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL bad_cmd_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_partial_write();
    logic [3:0] d, oe;
    logic [7:0] got [$];
    cs_begin();
    tx_byte(8'h02);
    tx_addr(24'h000080);
    for (int i = 0; i < 5; i++) cyc(4'h0, d, oe);
    qif.csb_i = 1'b1;
    #22;
    tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL partial_busy_early: got %b want 1", busy_o); end
    #6;
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL partial_busy_late: got %b want 0", busy_o); end
    #212;
    do_read(8'h03, 24'h000080, 2, got);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (got[i] !== model_mem[maddr(24'h80, i)])
        begin tests_failed++; $display("FAIL partial_mem[%0d]: got %h want %h", i, got[i], model_mem[maddr(24'h80, i)]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] d, oe;
    logic [7:0] got [$];
    cs_begin();
    tx_byte(8'h02);
    tx_addr(24'h000055);
    tx_byte(8'h00);
    for (int i = 0; i < 3; i++) cyc(4'h0, d, oe);
    rst_ni = 1'b1;
    qif.csb_i = 1'b1;
    #20;
    tests_run++; if (cmd_o !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_cmd: got %h want 00", cmd_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy: got %b want 0", busy_o); end
    #20;
    rst_ni = 1'b0;
    model_reset();
    #100;
    do_read(8'h03, 24'h000055, 2, got);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (got[i] !== model_mem[maddr(24'h55, i)])
        begin tests_failed++; $display("FAIL mid_reset_mem[%0d]: got %h want %h", i, got[i], model_mem[maddr(24'h55, i)]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  data [$];
    logic [7:0]  got [$];
    logic [23:0] a;
    logic [7:0]  pcmd, rcmd;
    int          n;
    for (int it = 0; it < 16; it++) begin
      a    = 24'($urandom);
      n    = $urandom_range(1, 4);
      data = {};
      for (int i = 0; i < n; i++) data.push_back(8'($urandom));
`ifdef QSPI_TARGET_QUAD_EN
      pcmd = ($urandom_range(0, 1) == 1) ? 8'h32 : 8'h02;
      rcmd = ($urandom_range(0, 1) == 1) ? 8'h6B : 8'h03;
`else
      pcmd = 8'h02;
      rcmd = 8'h03;
`endif
      do_program(pcmd, a, data);
      oe_bad = 0;
      do_read(rcmd, a, n + 1, got);
      for (int i = 0; i <= n; i++) begin
        tests_run++;
        if (got[i] !== model_mem[maddr(a, i)])
          begin tests_failed++; $display("FAIL random[%0d] cmd %h/%h addr %h byte %0d: got %h want %h", it, pcmd, rcmd, a, i, got[i], model_mem[maddr(a, i)]); end
      end
      tests_run++; if (oe_bad != 0) begin tests_failed++; $display("FAIL random_oe[%0d]: got %0d bad cycles want 0", it, oe_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_program_wrap();
    test_and_semantics();
    test_quad();
    test_read_id();
    test_bad_cmd();
    test_partial_write();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qspi_flash_target.md
# qspi_flash_target

Synthesizable QSPI NOR-flash responder that sits on the far end of the controller's `csb`/`sclk`/`sio[3:0]` pins. It is used as the on-chip target in integration benches and FPGA loop-back builds. The block oversamples the serial interface in the `clk_i` domain and decodes a command byte, a 24-bit address and optional dummy cycles. It then serves reads from, or programs, an internal byte array in single or quad data mode. SPI mode 0 only: sample on rising `sclk`, drive on falling `sclk`.

## Interface
- `ADDR_W`, 8, log2 of the internal array size in bytes; only address bits `[ADDR_W-1:0]` are used.
- `DUMMY_CYCLES`, 8, number of dummy `sclk` cycles for quad output read.
- `ID_VALUE`, 24'hEF4018, JEDEC ID returned by READ ID, MSB first.

Ports:
- `clk_i`  in  1  system clock; must be at least 4x the `sclk_i` frequency.
- `rst_ni`  in  1  reset, asynchronous, active-high.
- `sclk_i`  in  1  serial clock from the controller; asynchronous to `clk_i`.
- `csb_i`  in  1  chip select, active low.
- `sio_i`  in  4  serial data in; `sio_i[0]` is MOSI in single mode.
- `sio_o`  out  4  serial data out; `sio_o[1]` is MISO in single mode.
- `sio_oe`  out  4  per-line output enable.
- `busy_o`  out  1  high while a transaction is in progress (synchronized `csb` low).
- `cmd_o`  out  8  last decoded command byte.
- `cmd_valid_o`  out  1  one-cycle pulse when `cmd_o` updates.
- `err_o`  out  1  one-cycle pulse on an unsupported command.

## Operation
- **Input synchronization:** `sclk_i`, `csb_i` and `sio_i` each pass through 2-flop synchronizers. Rise and fall strobes are derived from the synchronized `sclk`, and all logic below acts on those strobes.
- **States:** IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, ID, DISCARD.
- **IDLE -> CMD:** on synchronized `csb` falling. Bit and byte counters clear.
- **CMD:** shift in 8 bits from `sio[0]` MSB first. On the 8th rise, update `cmd_o` and pulse `cmd_valid_o`, then decode:
  - 03 READ -> ADDR, then RDATA single.
  - 6B QUAD OUTPUT READ -> ADDR, then DUMMY, then RDATA quad.
  - 02 PAGE PROGRAM -> ADDR, then WDATA single.
  - 32 QUAD PAGE PROGRAM -> ADDR, then WDATA quad.
  - 9F READ ID -> ID.
  - Any other value -> pulse `err_o`, go to DISCARD.
- **ADDR:** 24 rises on `sio[0]`, MSB first. DUMMY counts `DUMMY_CYCLES` rises; data is ignored and `sio_oe` = 0.
- **RDATA:**
  - Load the byte at the address into the shift register on entry, and again after every completed byte.
  - Address increments per byte and wraps from `2^ADDR_W-1` to 0.
  - Single mode: `sio_oe`=4'b0010, bit 7 first.
  - Quad mode: `sio_oe`=4'b1111, `sio_o` = byte[7:4] then byte[3:0].
- **WDATA:**
  - Collect 8 bits (single, `sio[0]`) or 2 nibbles (quad, high nibble first).
  - On completion, write `mem[addr] <= mem[addr] & data`; programming only clears bits. Then increment with wrap.
  - `sio_oe`=0 throughout.
- **ID:** shift out `ID_VALUE` on `sio[1]`, MSB first. Repeat from the MSB after 24 bits.
- **DISCARD:** all outputs idle until `csb` rises.
- **`csb` rise in any state:** return to IDLE and clear `sio_oe`.
  - A partial write byte is dropped.
  - A partial read byte is abandoned.
- **Memory at reset:** every byte = 8'hFF (erased flash).

## Timing
- **Reset values:** `sio_o`=0, `sio_oe`=0, `busy_o`=0, `cmd_o`=0, `cmd_valid_o`=0, `err_o`=0. State IDLE, counters 0.
- **Input latency:** pin-to-strobe latency is 3 `clk_i` cycles (2 sync + 1 edge detect).
- **Output timing:**
  - `sio_o` and `sio_oe` update 1 cycle after the falling strobe, i.e. 4 `clk_i` after `sclk_i` falls.
  - The first data bit of RDATA/ID is driven after the falling edge that ends the last address or dummy cycle, so it is valid before the next rise.
- **`busy_o`:** follows synchronized `csb`, 3 cycles of latency.
- **`cmd_valid_o` / `err_o`:** asserted in the cycle after the 8th command rise strobe.
- **Same-cycle events:** if the `csb` rise strobe coincides with a byte-completing `sclk` rise strobe, `csb` wins and the byte is not written.
- **Asynchronous reset mid-transaction:** returns to IDLE immediately and reinitializes memory to FF.

## Configuration
- **`QSPI_TARGET_QUAD_EN` defined:** commands 6B and 32 are supported, and the DUMMY state and quad datapath are present.
- **`QSPI_TARGET_QUAD_EN` undefined:**
  - 6B and 32 are unsupported (pulse `err_o`, go to DISCARD).
  - `sio_oe[3:2]` and `sio_oe[0]` are tied to 0, `sio_o[3:2]` and `sio_o[0]` are tied to 0, and the DUMMY state is removed.

## Test plan
- After reset, READ 03 at addr 0x000010 for 2 bytes -> `sio[1]` returns 0xFF, 0xFF; `cmd_o`=8'h03 with one `cmd_valid_o` pulse.
- PAGE PROGRAM 02 at 0x0000FE with bytes 0xA5, 0x3C, 0x0F -> mem[FE]=A5, mem[FF]=3C, mem[00]=0F (wrap). A following READ of 3 bytes from 0xFE returns A5 3C 0F.
- Program 0xF0 then 0x3C to addr 0x20 -> mem[20]=0x30 (AND semantics).
- QUAD PAGE PROGRAM 32 to 0x40 with 0x12, 0x34, then QUAD READ 6B at 0x40 -> after 8 dummy cycles `sio_o` shows nibbles 1,2,3,4 with `sio_oe`=4'hF. With the macro undefined: `err_o` pulses and `sio_oe` stays 0.
- READ ID 9F clocked for 32 bits -> 0xEF,0x40,0x18,0xEF.
- Command 0xAB -> `err_o` pulse, no output for the rest of the transaction. Raise `csb` after 5 bits of a program byte -> memory unchanged, `busy_o` low 3 cycles later.
